// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder with synchroniser, warm-up blanking, illegal-transition
// detection and a loadable modulo-2^WIDTH position counter. Optional macro: QUAD_GLITCH_FILTER_EN.
module quad_decoder_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out,
    output logic             step_out,
    output logic             dir_out,
    output logic             err_out
);

`ifdef QUAD_GLITCH_FILTER_EN
    localparam int WARM_CYCLES = SYNC_STAGES + 3;
`else
    localparam int WARM_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int WARM_W = $clog2(WARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0][1:0] r_sync;
    logic [1:0]                  r_prev;
    logic [WARM_W-1:0]           r_warm_cnt;
    logic [WIDTH-1:0]            r_q;
    logic                        r_step;
    logic                        r_dir;
    logic                        r_err;

    logic [1:0] w_ab_sync;
    logic [1:0] w_ab_s;
    logic       w_warm;
    logic [1:0] w_pos_prev;
    logic [1:0] w_pos_cur;
    logic [1:0] w_delta;
    logic       w_up;
    logic       w_dn;
    logic       w_bad;

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {a_in, b_in}};
        end
    end

    assign w_ab_sync = r_sync[SYNC_STAGES-1];

`ifdef QUAD_GLITCH_FILTER_EN
    // Accept a new value only once three consecutive synchronised samples agree;
    // the decision is combinational so the accepted value is seen on the same edge.
    logic [1:0] r_hist1;
    logic [1:0] r_hist2;
    logic [1:0] r_filt;
    logic       w_stable;

    assign w_stable = (w_ab_sync == r_hist1) && (r_hist1 == r_hist2);
    assign w_ab_s   = w_stable ? w_ab_sync : r_filt;

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_hist1 <= 2'b00;
            r_hist2 <= 2'b00;
            r_filt  <= 2'b00;
        end else begin
            r_hist1 <= w_ab_sync;
            r_hist2 <= r_hist1;
            r_filt  <= w_ab_s;
        end
    end
`else
    assign w_ab_s = w_ab_sync;
`endif

    assign w_warm = (r_warm_cnt < WARM_W'(WARM_CYCLES));

    // Gray code to 2-bit position: the step direction is the modulo-4 position difference.
    assign w_pos_prev = {r_prev[1], r_prev[1] ^ r_prev[0]};
    assign w_pos_cur  = {w_ab_s[1], w_ab_s[1] ^ w_ab_s[0]};
    assign w_delta    = w_pos_cur - w_pos_prev;
    assign w_up       = !w_warm && (w_delta == 2'b01);
    assign w_dn       = !w_warm && (w_delta == 2'b11);
    assign w_bad      = !w_warm && (w_delta == 2'b10);

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_prev     <= 2'b00;
            r_warm_cnt <= '0;
            r_q        <= '0;
            r_step     <= 1'b0;
            r_dir      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_prev <= w_ab_s;
            r_step <= w_up | w_dn;
            r_err  <= w_bad;
            if (w_warm) begin
                r_warm_cnt <= r_warm_cnt + WARM_W'(1);
            end
            if (w_up | w_dn) begin
                r_dir <= w_up;
            end
            if (load_in) begin
                r_q <= d_in;
            end else if (w_up) begin
                r_q <= r_q + WIDTH'(1);
            end else if (w_dn) begin
                r_q <= r_q - WIDTH'(1);
            end
        end
    end

    assign q_out    = r_q;
    assign step_out = r_step;
    assign dir_out  = r_dir;
    assign err_out  = r_err;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Self-checking bench for quad_decoder_counter: directed steps followed by random
// A/B moves checked against a position-on-a-ring reference model.
module tb_quad_decoder_counter;
    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
`ifdef QUAD_GLITCH_FILTER_EN
    localparam int LAT = SYNC + 3;
`else
    localparam int LAT = SYNC + 1;
`endif
    localparam int HOLD = LAT + 1;

    logic             clk = 1'b0;
    logic             reset_in = 1'b0;
    logic             a_in = 1'b1;
    logic             b_in = 1'b1;
    logic             load_in = 1'b0;
    logic [WIDTH-1:0] d_in = '0;
    logic [WIDTH-1:0] q_out;
    logic             step_out;
    logic             dir_out;
    logic             err_out;

    quad_decoder_counter #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_in(reset_in), .a_in(a_in), .b_in(b_in),
        .load_in(load_in), .d_in(d_in), .q_out(q_out),
        .step_out(step_out), .dir_out(dir_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Encoder states in up-count order around the ring.
    logic [1:0]       ring [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0]       m_ab  = 2'b11;
    logic [WIDTH-1:0] m_q   = '0;
    logic             m_dir = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ring_pos(input logic [1:0] ab);
        for (int i = 0; i < 4; i++) if (ring[i] == ab) return i;
        return 0;
    endfunction

    task automatic check_all(input string tag, input logic exp_step, input logic exp_err);
        chk({tag, ".step"}, 32'(step_out), 32'(exp_step));
        chk({tag, ".err"},  32'(err_out),  32'(exp_err));
        chk({tag, ".dir"},  32'(dir_out),  32'(m_dir));
        chk({tag, ".q"},    32'(q_out),    32'(m_q));
    endtask

    // Move the pins to ab, hold HOLD clocks; optionally load ld on the cycle the move decodes.
    task automatic move(input logic [1:0] ab, input bit do_load, input logic [WIDTH-1:0] ld,
                        input string tag);
        int  steps;
        bit  ev_step;
        bit  ev_err;
        steps   = (ring_pos(ab) - ring_pos(m_ab) + 4) % 4;
        ev_step = (steps == 1) || (steps == 3);
        ev_err  = (steps == 2);
        @(negedge clk);
        {a_in, b_in} = ab;
        for (int k = 1; k <= HOLD; k++) begin
            if (k > 1) @(negedge clk);
            load_in = do_load && (k == LAT);
            d_in    = ld;
            @(posedge clk);
            #1;
            if (k == LAT) begin
                if (ev_step) m_dir = (steps == 1);
                if (do_load) m_q = ld;
                else if (steps == 1) m_q = m_q + 1'b1;
                else if (steps == 3) m_q = m_q - 1'b1;
            end
            check_all(tag, (k == LAT) && ev_step, (k == LAT) && ev_err);
        end
        load_in = 1'b0;
        m_ab = ab;
    endtask

    task automatic load_now(input logic [WIDTH-1:0] v, input string tag);
        @(negedge clk);
        load_in = 1'b1;
        d_in    = v;
        @(posedge clk);
        #1;
        m_q = v;
        check_all(tag, 1'b0, 1'b0);
        @(negedge clk);
        load_in = 1'b0;
    endtask

    // Reset for n clocks while the pins jump to ab, then confirm warm-up emits nothing.
    task automatic reset_pulse(input logic [1:0] ab, input int n, input string tag);
        @(negedge clk);
        reset_in = 1'b0;
        {a_in, b_in} = ab;
        m_q = '0;
        m_dir = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check_all({tag, ".rst"}, 1'b0, 1'b0);
        end
        @(negedge clk);
        reset_in = 1'b1;
        m_ab = ab;
        for (int k = 0; k < LAT + 4; k++) begin
            @(posedge clk);
            #1;
            check_all({tag, ".warm"}, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset_pulse(2'b11, 2, "init");

        move(2'b00, 1'b0, '0, "jump11_00");
        move(2'b01, 1'b0, '0, "up1");
        move(2'b11, 1'b0, '0, "up2");
        move(2'b10, 1'b0, '0, "up3");
        move(2'b00, 1'b0, '0, "up4");
        chk("q_after_up4", 32'(q_out), 32'd4);

        load_now(8'h00, "load0");
        move(2'b10, 1'b0, '0, "down_wrap");
        chk("q_wrap_ff", 32'(q_out), 32'hFF);
        move(2'b11, 1'b1, 8'hFE, "load_vs_step");
        move(2'b01, 1'b0, '0, "down2");
        move(2'b00, 1'b0, '0, "down3");
        move(2'b11, 1'b0, '0, "err00_11");
        move(2'b10, 1'b0, '0, "up_after_err");

        load_now(8'h04, "load4");
        move(2'b00, 1'b0, '0, "up_to5");
        chk("q_is5", 32'(q_out), 32'd5);
        reset_pulse(2'b01, 1, "mid_reset");

        load_now(8'hFF, "loadff");
        move(2'b11, 1'b0, '0, "up_wrap");
        chk("q_wrap_0", 32'(q_out), 32'd0);

`ifdef QUAD_GLITCH_FILTER_EN
        // Two-clock pulse on A from 00 must be swallowed by the filter.
        move(2'b00, 1'b0, '0, "to00");
        @(negedge clk);
        a_in = 1'b1;
        repeat (2) @(negedge clk);
        a_in = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(posedge clk);
            #1;
            check_all("glitch", 1'b0, 1'b0);
        end
        move(2'b10, 1'b0, '0, "filt_step");
`endif

        for (int i = 0; i < 300; i++) begin
            move(ring[$urandom_range(0, 3)], ($urandom_range(0, 3) == 0),
                 WIDTH'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/quad_decoder_counter.md
Name: quad_decoder_counter

Overview:
- Quadrature (A/B) decoder that produces the up/down step and direction information consumed by the team's synchronous up/down counters.
- Also integrates a loadable position counter.
- Sits between an external incremental encoder (asynchronous A/B pins) and the control logic that reads position.
- Adds input synchronisation, Gray-sequence decoding and illegal-transition detection.

Parameters:
- WIDTH, 8, position counter width in bits.
- SYNC_STAGES, 2, synchroniser flops per A/B input (legal 2..4).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_in  input  1  synchronous, active-low reset.
- a_in  input  1  encoder channel A, asynchronous.
- b_in  input  1  encoder channel B, asynchronous.
- load_in  input  1  load d_in into the position counter.
- d_in  input  WIDTH  load value.
- q_out  output  WIDTH  position count.
- step_out  output  1  one-cycle pulse per accepted quadrature step.
- dir_out  output  1  direction of last accepted step: 1 = up, 0 = down.
- err_out  output  1  one-cycle pulse on an illegal transition.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (ports clk, reset_in); sampled only on the rising clk edge.
  - While reset_in=0 at an edge: q_out=0, step_out=0, dir_out=0, err_out=0.
  - Synchroniser flops, prev_ab and the warm-up counter are cleared.
- Synchroniser: a_in/b_in each pass through SYNC_STAGES flops, giving ab_s = {a_s, b_s}.
- Warm-up:
  - After reset release, decoding is disabled for SYNC_STAGES+1 clocks.
  - During warm-up, prev_ab <= ab_s every cycle; no steps, no errors.
- Decode, every cycle after warm-up: compare prev_ab to ab_s, then prev_ab <= ab_s.
  - Up sequence: 00->01->11->10->00. Each such transition gives step_out=1, dir_out<=1, q_out+1.
  - Down sequence: 00->10->11->01->00. Each such transition gives step_out=1, dir_out<=0, q_out-1.
  - No change: step_out=0, q_out held, dir_out held.
  - Both bits change (00<->11, 01<->10): err_out=1, step_out=0, q_out and dir_out unchanged.
- Latency: a pin change stable before an edge produces step_out/q_out update SYNC_STAGES+1 clocks later.
- Arithmetic: modulo 2^WIDTH.
  - Up from all-ones wraps to 0.
  - Down from 0 wraps to all-ones.
  - No saturation, no carry output.
- load_in=1: q_out <= d_in next edge. Load has priority over a simultaneous step.
  - step_out, dir_out and err_out still report the decoded event in that cycle.
  - The step is not applied to the count.
- Reset mid-operation:
  - Any reset edge aborts all state; in-flight transitions in the synchroniser are discarded.
  - Warm-up restarts, so no spurious step or error is emitted after reset.
- Outputs q_out, step_out, dir_out and err_out are all registered.

Optional Feature:
- Macro QUAD_GLITCH_FILTER_EN.
- Defined:
  - A 3-cycle stability filter follows the synchroniser.
  - ab_s is replaced by the filtered value, which updates only when the synchronised A/B value has been identical for 3 consecutive clocks.
  - Latency becomes SYNC_STAGES+3 clocks.
  - A pulse shorter than 3 clocks is ignored: no step, no error.
  - Warm-up extends to SYNC_STAGES+3 clocks.
  - The filter register resets to 00.
- Undefined: no filter; behaviour exactly as above.

Test Plan:
- Reset then warm-up with a/b held at 11 -> no step_out and no err_out ever; q_out=0.
- Drive 00,01,11,10,00, each held 4 clocks (WIDTH=8, SYNC_STAGES=2):
  - 4 step_out pulses, dir_out=1, q_out=4.
  - First pulse 3 clocks after the first change.
- From q_out=0, drive the down sequence 00,10 -> q_out=8'hFF, dir_out=0. Then load_in=1, d_in=8'hFE while the next down step decodes -> q_out=8'hFE, step_out=1, count not decremented.
- Jump a/b 00->11 directly -> err_out single pulse, step_out=0, q_out unchanged. Then continue 11->10 -> legal up step, q_out+1.
- Assert reset_in=0 one clock mid-sequence after q_out=5 -> q_out=0 next edge; no step/err during the following SYNC_STAGES+1 clocks.
- With QUAD_GLITCH_FILTER_EN: 2-clock pulse on a_in from 00 -> no step_out. 3-clock-stable change -> one step_out, SYNC_STAGES+3 clocks after the change.
